adder_arbiter: RTL and testbench



---
 rtl/adder_arbiter_pkg.sv | 17 +
 rtl/adder_arbiter_adder.sv | 40 ++++
 rtl/adder_arbiter.sv | 127 ++++++++++++
 tb/tb_adder_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the ex-stage adder arbiter: requester IDs,
// flag bit positions and the default datapath width.
package adder_arbiter_pkg;

    localparam int DATA_W_DEF = 32;

    // Requester IDs as carried on id_o
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_AGU = 1'b1;

    // Bit positions inside the 4-bit flags word {zero, pos, neg, overflow}
    localparam int FLAG_ZERO = 3;
    localparam int FLAG_POS  = 2;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_OVF  = 0;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Shared add/sub datapath: result wraps modulo 2^DATA_W, flags describe
// the wrapped result plus signed overflow of the selected operation.
module adder_arbiter_adder
    import adder_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] opr0_i,
    input  logic [DATA_W-1:0] opr1_i,
    input  logic              minus_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    logic signed [DATA_W-1:0] opr0_s;
    logic signed [DATA_W-1:0] opr1_eff_s;
    logic signed [DATA_W-1:0] sum_s;

    // Overflow when both effective addends share a sign the sum does not
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Subtraction is opr0 + ~opr1 + 1, so one adder covers both operations
    always_comb begin
        opr0_s     = opr0_i;
        opr1_eff_s = minus_i ? ~opr1_i : opr1_i;
        sum_s      = opr0_s + opr1_eff_s + {{(DATA_W-1){1'b0}}, minus_i};

        result_o            = sum_s;
        flags_o             = '0;
        flags_o[FLAG_ZERO]  = (sum_s == '0);
        flags_o[FLAG_NEG]   = sum_s[DATA_W-1];
        flags_o[FLAG_POS]   = (sum_s != '0) && !sum_s[DATA_W-1];
        flags_o[FLAG_OVF]   = signed_ovf(opr0_s[DATA_W-1], opr1_eff_s[DATA_W-1],
                                         sum_s[DATA_W-1]);
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between the ALU (r0) and the AGU
// (r1). One registered, ID-tagged result per cycle with valid/stall
// handshake on both sides and a saturating conflict counter.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_v_i,
    input  logic [DATA_W-1:0] r0_opr0_i,
    input  logic [DATA_W-1:0] r0_opr1_i,
    input  logic              r0_minus_i,
    output logic              r0_stall_o,
    input  logic              r1_v_i,
    input  logic [DATA_W-1:0] r1_opr0_i,
    input  logic [DATA_W-1:0] r1_opr1_i,
    input  logic              r1_minus_i,
    output logic              r1_stall_o,
    output logic              v_o,
    output logic              id_o,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o,
    input  logic              stall_i,
    output logic [CNT_W-1:0]  conflict_cnt_o
);

    logic              v_q, v_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              gnt_v;
    logic              gnt_id;
    logic              can_accept;
    logic              accept;
    logic [DATA_W-1:0] mux_opr0;
    logic [DATA_W-1:0] mux_opr1;
    logic              mux_minus;
    logic [DATA_W-1:0] add_result;
    logic [3:0]        add_flags;

    // Grant selection: a lone requester wins, a conflict goes to the one not served last
    always_comb begin
        gnt_v      = r0_v_i || r1_v_i;
        if (r0_v_i && r1_v_i) begin
            gnt_id = ~last_grant_q;
        end else if (r1_v_i) begin
            gnt_id = REQ_AGU;
        end else begin
            gnt_id = REQ_ALU;
        end
        can_accept = !v_q || !stall_i;
        accept     = gnt_v && can_accept;
        r0_stall_o = r0_v_i && !(accept && (gnt_id == REQ_ALU));
        r1_stall_o = r1_v_i && !(accept && (gnt_id == REQ_AGU));
    end

    // Winner's operands feed the shared adder
    always_comb begin
        mux_opr0  = (gnt_id == REQ_AGU) ? r1_opr0_i  : r0_opr0_i;
        mux_opr1  = (gnt_id == REQ_AGU) ? r1_opr1_i  : r0_opr1_i;
        mux_minus = (gnt_id == REQ_AGU) ? r1_minus_i : r0_minus_i;
    end

    adder_arbiter_adder #(
        .DATA_W (DATA_W)
    ) u_adder (
        .opr0_i   (mux_opr0),
        .opr1_i   (mux_opr1),
        .minus_i  (mux_minus),
        .result_o (add_result),
        .flags_o  (add_flags)
    );

    // Next state: load on accept, drain when the consumer takes a result and nothing replaces it
    always_comb begin
        v_d          = v_q;
        id_d         = id_q;
        result_d     = result_q;
        flags_d      = flags_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (accept) begin
            v_d          = 1'b1;
            id_d         = gnt_id;
            result_d     = add_result;
            flags_d      = add_flags;
            last_grant_d = gnt_id;
        end else if (!stall_i) begin
            v_d = 1'b0;
        end
        if (r0_v_i && r1_v_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops any pending result and re-arms r0 priority
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q          <= 1'b0;
            id_q         <= REQ_ALU;
            result_q     <= '0;
            flags_q      <= '0;
            last_grant_q <= REQ_AGU;
            cnt_q        <= '0;
        end else begin
            v_q          <= v_d;
            id_q         <= id_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign v_o            = v_q;
    assign id_o           = id_q;
    assign result_o       = result_q;
    assign flags_o        = flags_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: queued requesters, cycle reference model,
// scoreboard of expected results and a separate output monitor.
module tb_adder_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_v_i, r0_minus_i, r0_stall_o;
    logic [DW-1:0] r0_opr0_i, r0_opr1_i;
    logic          r1_v_i, r1_minus_i, r1_stall_o;
    logic [DW-1:0] r1_opr0_i, r1_opr1_i;
    logic          v_o, id_o, stall_i;
    logic [DW-1:0] result_o;
    logic [3:0]    flags_o;
    logic [CW-1:0] conflict_cnt_o;

    adder_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .r0_v_i         (r0_v_i),
        .r0_opr0_i      (r0_opr0_i),
        .r0_opr1_i      (r0_opr1_i),
        .r0_minus_i     (r0_minus_i),
        .r0_stall_o     (r0_stall_o),
        .r1_v_i         (r1_v_i),
        .r1_opr0_i      (r1_opr0_i),
        .r1_opr1_i      (r1_opr1_i),
        .r1_minus_i     (r1_minus_i),
        .r1_stall_o     (r1_stall_o),
        .v_o            (v_o),
        .id_o           (id_o),
        .result_o       (result_o),
        .flags_o        (flags_o),
        .stall_i        (stall_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          m;
    } op_t;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] res;
        logic [3:0]    fl;
    } exp_t;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    bit took0 = 1'b0;
    bit took1 = 1'b0;
    bit m_v    = 1'b0;
    bit m_last = 1'b1;
    int m_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: exact signed arithmetic, then wrap and derive flags
    function automatic exp_t ref_op(input logic id, input op_t op);
        longint sa, sbv, ex;
        logic [DW-1:0] r;
        exp_t e;
        sa  = longint'($signed(op.a));
        sbv = longint'($signed(op.b));
        ex  = op.m ? (sa - sbv) : (sa + sbv);
        r   = ex[DW-1:0];
        e.id    = id;
        e.res   = r;
        e.fl[3] = (r == 0);
        e.fl[1] = r[DW-1];
        e.fl[2] = (r != 0) && !r[DW-1];
        e.fl[0] = (ex != longint'($signed(r)));
        return e;
    endfunction

    function automatic logic [DW-1:0] rand_opr();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return DW'($urandom_range(0, 15));
            3:       return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic drive();
        r0_v_i = (q0.size() != 0);
        r1_v_i = (q1.size() != 0);
        {r0_opr0_i, r0_opr1_i, r0_minus_i} = r0_v_i ? q0[0] : '0;
        {r1_opr0_i, r1_opr1_i, r1_minus_i} = r1_v_i ? q1[0] : '0;
    endtask

    task automatic enq0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        op_t op;
        op.a = a; op.b = b; op.m = m;
        q0.push_back(op);
        drive();
    endtask

    task automatic enq1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
        op_t op;
        op.a = a; op.b = b; op.m = m;
        q1.push_back(op);
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (took0) void'(q0.pop_front());
        if (took1) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_idle(input int limit);
        int i;
        i = 0;
        while ((q0.size() != 0 || q1.size() != 0 || v_o) && i < limit) begin
            step();
            i++;
        end
        chk("idle_timeout", (i >= limit), 0);
    endtask

    // Reference model: decides acceptance, predicts stalls, queues expected results
    bit mdl_any, mdl_win, mdl_acc;
    always @(negedge clk) begin
        chk("v_o", v_o, m_v);
        chk("conflict_cnt", conflict_cnt_o, m_cnt);
        mdl_any = r0_v_i || r1_v_i;
        mdl_win = (r0_v_i && r1_v_i) ? !m_last : r1_v_i;
        mdl_acc = mdl_any && (!m_v || !stall_i);
        chk("r0_stall", r0_stall_o, r0_v_i && !(mdl_acc && !mdl_win));
        chk("r1_stall", r1_stall_o, r1_v_i && !(mdl_acc && mdl_win));
        took0 = mdl_acc && !rst && !mdl_win;
        took1 = mdl_acc && !rst && mdl_win;
        if (rst) begin
            m_v    = 1'b0;
            m_last = 1'b1;
            m_cnt  = 0;
            sb.delete();
        end else begin
            if (r0_v_i && r1_v_i && m_cnt < (1 << CW) - 1) m_cnt++;
            if (mdl_acc) begin
                if (mdl_win) sb.push_back(ref_op(1'b1, {r1_opr0_i, r1_opr1_i, r1_minus_i}));
                else         sb.push_back(ref_op(1'b0, {r0_opr0_i, r0_opr1_i, r0_minus_i}));
                m_v    = 1'b1;
                m_last = mdl_win;
            end else if (!stall_i) begin
                m_v = 1'b0;
            end
        end
    end

    // Monitor: compares each result as it is handed downstream, and checks hold stability
    exp_t          mon_e;
    logic          prev_v = 1'b0, prev_stall = 1'b0, prev_rst = 1'b1, prev_id = 1'b0;
    logic [DW-1:0] prev_res = '0;
    logic [3:0]    prev_fl = '0;
    always @(negedge clk) begin
        if (!rst && v_o === 1'b1 && !stall_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("id", id_o, mon_e.id);
                chk("result", result_o, mon_e.res);
                chk("flags", flags_o, mon_e.fl);
            end
        end
        if (prev_v && prev_stall && !prev_rst) begin
            chk("hold", {v_o, id_o, result_o, flags_o}, {1'b1, prev_id, prev_res, prev_fl});
        end
        prev_v     = v_o;
        prev_stall = stall_i;
        prev_rst   = rst;
        prev_id    = id_o;
        prev_res   = result_o;
        prev_fl    = flags_o;
    end

    // Requester rule: a stalled request keeps its valid and operands
    property req0_hold;
        @(posedge clk) disable iff (rst)
        r0_stall_o |=> ($stable(r0_v_i) && $stable(r0_opr0_i) && $stable(r0_opr1_i) && $stable(r0_minus_i));
    endproperty
    property req1_hold;
        @(posedge clk) disable iff (rst)
        r1_stall_o |=> ($stable(r1_v_i) && $stable(r1_opr0_i) && $stable(r1_opr1_i) && $stable(r1_minus_i));
    endproperty
    a_req0_hold: assert property (req0_hold) else begin n_chk++; $display("FAIL req0_hold at %0t", $time); end
    a_req1_hold: assert property (req1_hold) else begin n_chk++; $display("FAIL req1_hold at %0t", $time); end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst     = 1'b1;
        stall_i = 1'b0;
        drive();

        // Reset held two edges with both requesters valid, then r0 wins first conflict
        enq0(32'd1, 32'd1, 1'b0);
        enq1(32'h100, 32'h4, 1'b0);
        step();
        step();
        rst = 1'b0;
        wait_idle(50);

        // Single requester subtract
        enq0(32'd5, 32'd3, 1'b1);
        wait_idle(50);

        // Back-pressure: result 7 held for 3 cycles while r1 waits
        enq0(32'd3, 32'd4, 1'b0);
        guard = 0;
        while (q0.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        stall_i = 1'b1;
        enq1(32'h10, 32'h20, 1'b0);
        repeat (3) step();
        stall_i = 1'b0;
        wait_idle(50);

        // Edge arithmetic
        enq1(32'h7FFF_FFFF, 32'd1, 1'b0);
        enq0(32'h8000_0000, 32'd1, 1'b1);
        enq0(32'd9, 32'd9, 1'b1);
        wait_idle(50);

        // Randomised traffic with random back-pressure
        repeat (400) begin
            if (q0.size() == 0 && $urandom_range(0, 2) != 0) enq0(rand_opr(), rand_opr(), 1'($urandom_range(0, 1)));
            if (q1.size() == 0 && $urandom_range(0, 2) != 0) enq1(rand_opr(), rand_opr(), 1'($urandom_range(0, 1)));
            stall_i = ($urandom_range(0, 3) == 0);
            step();
        end
        stall_i = 1'b0;
        wait_idle(100);

        // Saturation burst, then reset in the middle of it
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            enq0(rand_opr(), rand_opr(), 1'($urandom_range(0, 1)));
            enq1(rand_opr(), rand_opr(), 1'($urandom_range(0, 1)));
        end
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_idle(200);

        repeat (3) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
